// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, operand modes, sequencer states and field helpers for cpu_core_mc
package cpu_pkg;

    localparam logic [4:0] OP_NOP  = 5'h00;
    localparam logic [4:0] OP_MOV  = 5'h01;
    localparam logic [4:0] OP_ADD  = 5'h02;
    localparam logic [4:0] OP_SUB  = 5'h03;
    localparam logic [4:0] OP_AND  = 5'h04;
    localparam logic [4:0] OP_OR   = 5'h05;
    localparam logic [4:0] OP_XOR  = 5'h06;
    localparam logic [4:0] OP_SHL  = 5'h07;
    localparam logic [4:0] OP_SHR  = 5'h08;
    localparam logic [4:0] OP_LD   = 5'h09;
    localparam logic [4:0] OP_ST   = 5'h0A;
    localparam logic [4:0] OP_JMP  = 5'h0B;
    localparam logic [4:0] OP_JZ   = 5'h0C;
    localparam logic [4:0] OP_JNZ  = 5'h0D;
    localparam logic [4:0] OP_HALT = 5'h1F;

    localparam logic [1:0] MODE_LIT = 2'b00;
    localparam logic [1:0] MODE_REG = 2'b01;

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_e;

    // Field LSB positions; the literal always starts at bit 0.
    function automatic int inst_width(input int raddr_w, input int data_w);
        return 7 + 2 * raddr_w + data_w;
    endfunction

    function automatic int op_lsb(input int raddr_w, input int data_w);
        return 2 + 2 * raddr_w + data_w;
    endfunction

    function automatic int mode_lsb(input int raddr_w, input int data_w);
        return 2 * raddr_w + data_w;
    endfunction

    function automatic int dst_lsb(input int raddr_w, input int data_w);
        return raddr_w + data_w;
    endfunction

    function automatic int src_lsb(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational ALU producing result, zero and carry/borrow/shift-out
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [4:0]        op_i,
    output logic [DATA_W-1:0] result_o,
    output logic              z_o,
    output logic              c_o
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0] sh;
    logic [DATA_W:0] wide;

    always_comb begin
        sh       = b_i[SH_W-1:0];
        wide     = '0;
        result_o = b_i;
        c_o      = 1'b0;
        case (op_i)
            OP_ADD: begin
                wide     = {1'b0, a_i} + {1'b0, b_i};
                result_o = wide[DATA_W-1:0];
                c_o      = wide[DATA_W];
            end
            OP_SUB: begin
                wide     = {1'b0, a_i} - {1'b0, b_i};
                result_o = wide[DATA_W-1:0];
                c_o      = wide[DATA_W];
            end
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            // The guard bit catches the last bit shifted out; a zero shift leaves it 0.
            OP_SHL: begin
                wide     = {1'b0, a_i} << sh;
                result_o = wide[DATA_W-1:0];
                c_o      = wide[DATA_W];
            end
            OP_SHR: begin
                wide     = {a_i, 1'b0} >> sh;
                result_o = wide[DATA_W:1];
                c_o      = wide[0];
            end
            default: ;
        endcase
        z_o = (result_o == '0);
    end

endmodule

// File: rtl/cpu_core_mc.sv
// rtl/cpu_core_mc.sv - multi-cycle core with req/ack instruction and data memory ports
module cpu_core_mc
    import cpu_pkg::*;
#(
    parameter int  DATA_W  = 32,
    parameter int  RADDR_W = 5,
    parameter int  PC_W    = 6,
    parameter int  DADDR_W = 8,
    localparam int INST_W  = 7 + 2 * RADDR_W + DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INST_W-1:0]  imem_data,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_ack,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic [PC_W-1:0]    pc,
    output logic [INST_W-1:0]  inst,
    output logic               zflag,
    output logic               cflag,
    output logic               halted
);

    localparam int NREGS  = 2 ** RADDR_W;
    localparam int OP_L   = op_lsb(RADDR_W, DATA_W);
    localparam int MODE_L = mode_lsb(RADDR_W, DATA_W);
    localparam int DST_L  = dst_lsb(RADDR_W, DATA_W);
    localparam int SRC_L  = src_lsb(DATA_W);

    state_e             state_q;
    logic [DATA_W-1:0]  regs_q [NREGS];
    logic [PC_W-1:0]    pc_q;
    logic [INST_W-1:0]  inst_q;
    logic               z_q, c_q, halted_q;
    logic               imem_req_q, dmem_req_q, dmem_we_q;
    logic [DADDR_W-1:0] dmem_addr_q;
    logic [DATA_W-1:0]  dmem_wdata_q;

    logic [4:0]         opcode;
    logic [1:0]         mode;
    logic [RADDR_W-1:0] dst, src, breg;
    logic [DATA_W-1:0]  lit, a_val, b_val, dst_val, alu_res;
    logic               alu_z, alu_c;
    logic [PC_W-1:0]    pc_inc, jmp_tgt;

    assign opcode  = inst_q[OP_L +: 5];
    assign mode    = inst_q[MODE_L +: 2];
    assign dst     = inst_q[DST_L +: RADDR_W];
    assign src     = inst_q[SRC_L +: RADDR_W];
    assign lit     = inst_q[DATA_W-1:0];
    assign breg    = lit[RADDR_W-1:0];

    // R0 is hard-wired to zero on every read port.
    assign a_val   = (src  == '0) ? '0 : regs_q[src];
    assign dst_val = (dst  == '0) ? '0 : regs_q[dst];
    assign b_val   = (mode == MODE_REG) ? ((breg == '0) ? '0 : regs_q[breg]) : lit;

    assign pc_inc  = pc_q + 1'b1;
    assign jmp_tgt = lit[PC_W-1:0];

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .a_i      (a_val),
        .b_i      (b_val),
        .op_i     (opcode),
        .result_o (alu_res),
        .z_o      (alu_z),
        .c_o      (alu_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= '0;
            inst_q       <= '0;
            z_q          <= 1'b0;
            c_q          <= 1'b0;
            halted_q     <= 1'b0;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    // Once raised, the request is held until acked even if run drops.
                    if (imem_req_q && imem_ack) begin
                        inst_q     <= imem_data;
                        imem_req_q <= 1'b0;
                        state_q    <= S_EXEC;
                    end else if (!imem_req_q) begin
                        imem_req_q <= run;
                    end
                end
                S_EXEC: begin
                    state_q    <= S_FETCH;
                    imem_req_q <= run;
                    case (opcode)
                        OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
                            if (dst != '0) regs_q[dst] <= alu_res;
                            z_q  <= alu_z;
                            c_q  <= alu_c;
                            pc_q <= pc_inc;
                        end
                        OP_JMP: pc_q <= jmp_tgt;
                        OP_JZ:  pc_q <= z_q ? jmp_tgt : pc_inc;
                        OP_JNZ: pc_q <= z_q ? pc_inc : jmp_tgt;
                        OP_LD, OP_ST: begin
                            state_q      <= S_MEM;
                            imem_req_q   <= 1'b0;
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= (opcode == OP_ST);
                            dmem_addr_q  <= a_val[DADDR_W-1:0] + lit[DADDR_W-1:0];
                            dmem_wdata_q <= dst_val;
                        end
                        OP_HALT: begin
                            state_q    <= S_HALT;
                            imem_req_q <= 1'b0;
                            halted_q   <= 1'b1;
                        end
                        default: pc_q <= pc_inc;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (!dmem_we_q && dst != '0) regs_q[dst] <= dmem_rdata;
                        dmem_req_q <= 1'b0;
                        pc_q       <= pc_inc;
                        imem_req_q <= run;
                        state_q    <= S_FETCH;
                    end
                end
                S_HALT: ;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign zflag      = z_q;
    assign cflag      = c_q;
    assign halted     = halted_q;

endmodule

// File: doc/cpu_core_mc.md
Name: cpu_core_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle 49-bit-instruction CPU.
- Fetches from an external instruction memory and accesses an external data memory, both over req/ack handshakes, so memories of any latency can be attached.
- Holds the register file, PC, Z/C flags and a FETCH/EXEC/MEM/HALT sequencer.
- Sits between the instruction ROM and the data RAM in the top level.

Parameters:
- DATA_W, 32, datapath, register and literal width.
- RADDR_W, 5, register-address width; the register file holds 2**RADDR_W registers.
- PC_W, 6, program-counter width.
- DADDR_W, 8, data-memory address width.
- INST_W, 7+2*RADDR_W+DATA_W (=49), instruction width; derived, do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- run  in  1  fetch enable; 0 holds the core in FETCH without issuing a request.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address, always equal to pc.
- imem_ack  in  1  one-cycle pulse; imem_data is valid in the same cycle.
- imem_data  in  INST_W  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  DADDR_W  data address.
- dmem_wdata  out  DATA_W  store data.
- dmem_ack  in  1  one-cycle pulse; dmem_rdata is valid in the same cycle.
- dmem_rdata  in  DATA_W  load data.
- pc  out  PC_W  current PC.
- inst  out  INST_W  latched instruction.
- zflag  out  1  zero flag.
- cflag  out  1  carry flag.
- halted  out  1  high while in HALT.

Behaviour:
- Reset: applied synchronously on rst=1, and may occur in any state, including mid-handshake.
  - State returns to FETCH.
  - pc, inst, zflag, cflag, halted and all registers clear to 0.
  - imem_req and dmem_req are 0 from the cycle after rst is sampled.
- Instruction fields, MSB to LSB: opcode[4:0], mode[1:0], dst[RADDR_W], src[RADDR_W], lit[DATA_W].
- Operands:
  - A = R[src].
  - B = lit when mode=00; B = R[lit[RADDR_W-1:0]] when mode=01.
  - R0 always reads as 0; writes to R0 are discarded.
- Opcodes: 00 NOP, 01 MOV (B), 02 ADD, 03 SUB, 04 AND, 05 OR, 06 XOR, 07 SHL, 08 SHR, 09 LD, 0A ST, 0B JMP, 0C JZ, 0D JNZ, 1F HALT. All others execute as NOP.
- FETCH:
  - imem_req = run; imem_addr = pc.
  - On imem_ack with imem_req high: latch inst, go to EXEC.
  - An ack with req low is ignored.
- EXEC, ALU ops:
  - Write R[dst]; Z = (result == 0).
  - C = carry-out (ADD), borrow (SUB), or the last bit shifted out (SHL/SHR). Shift amount = B[$clog2(DATA_W)-1:0]; shift by 0 gives C = 0.
  - MOV and logic ops clear C.
  - pc <= pc+1, wrapping mod 2**PC_W; go to FETCH.
- EXEC, branches:
  - JMP: pc <= lit[PC_W-1:0].
  - JZ/JNZ: take the branch when Z=1 / Z=0 respectively; otherwise pc+1.
  - Flags are unchanged; go to FETCH.
- EXEC, NOP: pc+1; go to FETCH.
- EXEC, HALT: go to HALT; pc is not advanced.
- EXEC, LD/ST: go to MEM.
- MEM:
  - dmem_addr = (A + lit)[DADDR_W-1:0]; dmem_we = (opcode==ST); dmem_wdata = R[dst].
  - dmem_req is held high until dmem_ack.
  - On ack: LD writes dmem_rdata to R[dst]. LD and ST leave flags untouched.
  - Then pc+1; go to FETCH.
- HALT: halted = 1, no requests issued; only rst exits.
- run=0 mid-instruction: the current instruction completes; the core then idles in FETCH.
- Timing: with zero-wait acks (ack in the same cycle as req), ALU and branch instructions take 2 cycles and LD/ST take 3.
- Requests and addresses are registered; they never change while req is high and ack has not yet arrived.

Decomposition:
- cpu_pkg holds:
  - opcode localparams;
  - mode encodings;
  - state encoding (FETCH, EXEC, MEM, HALT);
  - field-slicing helper functions parametrised by RADDR_W and DATA_W.
- One sub-module, cpu_alu:
  - purely combinational;
  - inputs: A, B, opcode;
  - outputs: result, Z, C.
- The register file stays inline in cpu_core_mc.

Test Plan:
- rst mid-MEM with dmem_req=1 → next cycle dmem_req=0, pc=0, R1..R31=0, then a fetch from address 0 with run=1.
- Program "MOV R1,#5; ADD R2,R1,#0xFFFFFFFB; JZ 6" with zero-wait acks → R2=0, Z=1, C=1, pc=6 after 6 cycles.
- ST R1→[R0+#3], then LD R3←[R0+#3], with 4-cycle dmem ack latency → dmem_addr=3, dmem_we=1 then 0, R3=5, req held for 4 cycles each.
- PC wrap: JMP 63 followed by a NOP at 63 → next imem_addr=0.
- Write to R0 (MOV R0,#7) then ADD R4,R0,#0 → R4=0, Z=1.
- HALT with run held at 1 → halted=1, imem_req stays 0 for 20 cycles; rst → halted=0, fetch restarts at 0.
